// File: rtl/video_pkg.sv
// video_pkg: shared types and constants for the pattern generator.
// Stream sideband layout, pattern/state enums, bar palette.
package video_pkg;

  localparam int TUSER_BLANK = 3;
  localparam int TUSER_VSYNC = 2;
  localparam int TUSER_HSYNC = 1;
  localparam int TUSER_SOF   = 0;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Full-scale bar colour for index 0..7, each component BPC bits.
  function automatic logic [95:0] bar_color(
    input logic [2:0] idx,
    input int unsigned bpc
  );
    logic [2:0]  m;
    logic [31:0] fs;
    unique case (idx)
      3'd0: m = 3'b111;
      3'd1: m = 3'b110;
      3'd2: m = 3'b011;
      3'd3: m = 3'b010;
      3'd4: m = 3'b101;
      3'd5: m = 3'b100;
      3'd6: m = 3'b001;
      default: m = 3'b000;
    endcase
    fs = (32'd1 << bpc) - 32'd1;
    bar_color = ({64'd0, (m[2] ? fs : 32'd0)} << (2 * bpc))
              | ({64'd0, (m[1] ? fs : 32'd0)} << bpc)
              | {64'd0, (m[0] ? fs : 32'd0)};
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// video_pattern_gen_if: pixel stream bundle.
// tuser = {blank, vsync, hsync, sof}.
interface video_pattern_gen_if #(
  parameter int BPC = 8
) ();
  logic               tvalid;
  logic               tready;
  logic [3*BPC-1:0]   tdata;
  logic [3:0]         tuser;

  modport master (
    output tvalid, tdata, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tuser,
    output tready
  );
endinterface

// File: rtl/video_timing_ctr.sv
// video_timing_ctr: raster h/v counters and region flags.
// Coordinates/flags describe the beat to load next.
module video_timing_ctr
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1366,
  parameter int H_FP     = 14,
  parameter int H_SYNC   = 56,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_advance,
  output logic [HW-1:0] o_h,
  output logic [VW-1:0] o_v,
  output logic          o_blank,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_sof,
  output logic          o_last
);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_end;
  logic          w_v_end;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;

  assign w_h_end = (r_h == HW'(H_TOTAL - 1));
  assign w_v_end = (r_v == VW'(V_TOTAL - 1));
  assign o_last  = w_h_end && w_v_end;

  // Next-beat coordinate: current while idle, stepped while running.
  always_comb begin
    o_h = r_h;
    o_v = r_v;
    if (i_run) begin
      if (w_h_end) begin
        o_h = '0;
        o_v = w_v_end ? '0 : r_v + 1'b1;
      end else begin
        o_h = r_h + 1'b1;
      end
    end
  end

  // Counters move only on an accepted beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_advance) begin
      r_h <= o_h;
      r_v <= o_v;
    end
  end

  assign w_h32   = 32'(o_h);
  assign w_v32   = 32'(o_v);
  assign o_blank = (w_h32 >= 32'(H_ACTIVE)) ||
                   (w_v32 >= 32'(V_ACTIVE));
  assign o_hsync = (w_h32 >= 32'(H_ACTIVE + H_FP)) &&
                   (w_h32 <  32'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync = (w_v32 >= 32'(V_ACTIVE + V_FP)) &&
                   (w_v32 <  32'(V_ACTIVE + V_FP + V_SYNC));
  assign o_sof   = (w_h32 == 32'd0) && (w_v32 == 32'd0);

endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing plus selectable test pattern.
// Stream output with backpressure; pattern latched per frame.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int BPC        = 8,
  parameter int H_ACTIVE   = 1366,
  parameter int H_FP       = 14,
  parameter int H_SYNC     = 56,
  parameter int H_BP       = 64,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 28,
  parameter int RAMP_SHIFT = 0,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [1:0]           pattern_i,
  input  logic [3*BPC-1:0]     color_i,
  video_pattern_gen_if.master  out,
  output logic [15:0]          frame_cnt_o,
  output logic                 busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_load;
  logic             w_accept;
  pattern_e         r_pat;
  pattern_e         w_pat;
  logic [3*BPC-1:0] r_color;
  logic [3*BPC-1:0] w_color;
  logic [3*BPC-1:0] w_pix;
  logic [3*BPC-1:0] r_tdata;
  logic [3:0]       r_tuser;
  logic [3:0]       w_tuser;
  logic [2:0]       w_bar_idx;
  logic [95:0]      w_bar;
  logic [BPC-1:0]   w_ramp;
  logic             w_chk;
  logic [HW-1:0]    w_h;
  logic [VW-1:0]    w_v;
  logic             w_blank;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_sof;
  logic             w_last;

  assign w_accept = (r_state == RUN) && out.tready;

  video_timing_ctr #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_run     (r_state == RUN),
    .i_advance (w_accept),
    .o_h       (w_h),
    .o_v       (w_v),
    .o_blank   (w_blank),
    .o_hsync   (w_hsync),
    .o_vsync   (w_vsync),
    .o_sof     (w_sof),
    .o_last    (w_last)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Start on enable; stop only after the last beat of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable_i) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_last && !enable_i) begin
            w_load      = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The sof beat uses the live selection; later beats the latched one.
  assign w_pat   = w_sof ? pattern_e'(pattern_i) : r_pat;
  assign w_color = w_sof ? color_i : r_color;

  // Bar index by threshold compare; last bar takes the remainder.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (32'(w_h) >= 32'(k * BAR_W)) w_bar_idx = 3'(k);
    end
  end

  assign w_bar  = bar_color(w_bar_idx, BPC);
  assign w_ramp = BPC'(32'(w_h) >> RAMP_SHIFT);
  assign w_chk  = 1'((32'(w_h) ^ 32'(w_v)) >> CHECK_LOG2);

  // Pixel value of the beat being loaded.
  always_comb begin
    w_pix = '0;
    unique case (w_pat)
      PAT_SOLID: w_pix = w_color;
      PAT_BARS:  w_pix = w_bar[3*BPC-1:0];
      PAT_RAMP:  w_pix = {3{w_ramp}};
      PAT_CHECK: w_pix = w_chk ? '0 : w_color;
      default:   w_pix = '0;
    endcase
    if (w_blank) w_pix = '0;
  end

  // Sideband of the beat being loaded.
  always_comb begin
    w_tuser              = '0;
    w_tuser[TUSER_BLANK] = w_blank;
    w_tuser[TUSER_VSYNC] = w_vsync;
    w_tuser[TUSER_HSYNC] = w_hsync;
    w_tuser[TUSER_SOF]   = w_sof;
  end

  // Output register and per-frame selection latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tdata <= '0;
      r_tuser <= 4'b1000;
      r_pat   <= PAT_SOLID;
      r_color <= '0;
    end else if (w_load) begin
      r_tdata <= w_pix;
      r_tuser <= w_tuser;
      if (w_sof) begin
        r_pat   <= w_pat;
        r_color <= w_color;
      end
    end
  end

  // Completed-frame counter.
  always_ff @(posedge clk_i) begin
    if (rst_i)                 frame_cnt_o <= '0;
    else if (w_accept && w_last) frame_cnt_o <= frame_cnt_o + 16'd1;
  end

  assign out.tvalid = (r_state == RUN);
  assign out.tdata  = r_tdata;
  assign out.tuser  = r_tuser;
  assign busy_o     = (r_state == RUN);

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: scoreboard bench for video_pattern_gen.
// Random backpressure against a raster reference model.
module tb_video_pattern_gen;

  localparam int HA = 16, HFP = 2, HS = 2, HBP = 4;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FB = HT * VT;
  localparam int BPC = 8, RS = 0, CL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pat;
  logic [23:0] col;
  logic [15:0] fc;
  logic        busy;

  video_pattern_gen_if #(.BPC(BPC)) u_if ();

  video_pattern_gen #(
    .BPC(BPC), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RAMP_SHIFT(RS), .CHECK_LOG2(CL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .pattern_i(pat),
    .color_i(col), .out(u_if), .frame_cnt_o(fc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acc = 0;
  bit          rnd_rdy = 0;
  logic [27:0] expq[$];
  logic [27:0] got, exp_b, prev;
  bit          stall_prev = 0;

  function automatic logic [27:0] model(int h, int v, int p, logic [23:0] c);
    logic [23:0] bars [8];
    logic [23:0] d;
    logic [7:0]  g;
    int          idx;
    logic        bl, hs, vs, sf;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bl = (h >= HA) || (v >= VA);
    hs = (h >= HA + HFP) && (h < HA + HFP + HS);
    vs = (v >= VA + VFP) && (v < VA + VFP + VS);
    sf = (h == 0) && (v == 0);
    d = 24'h0;
    if (!bl) begin
      case (p)
        0: d = c;
        1: begin
          idx = h / (HA / 8);
          if (idx > 7) idx = 7;
          d = bars[idx];
        end
        2: begin
          g = 8'((h / (1 << RS)) % 256);
          d = {g, g, g};
        end
        default: begin
          if (((h / (1 << CL)) + (v / (1 << CL))) % 2 == 0) d = c;
          else d = 24'h0;
        end
      endcase
    end
    return {d, bl, vs, hs, sf};
  endfunction

  task automatic push_frame(int p, logic [23:0] c);
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++)
        expq.push_back(model(h, v, p, c));
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted beat, checks stalls.
  always @(negedge clk) begin
    got = {u_if.tdata, u_if.tuser};
    if (!rst) begin
      if (stall_prev) begin
        checks++;
        if (got !== prev || u_if.tvalid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", got, prev);
        end
      end
      if (u_if.tvalid && u_if.tready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL beat%0d: got %h want none", acc, got);
        end else begin
          exp_b = expq.pop_front();
          if (got !== exp_b) begin
            errors++;
            $display("FAIL beat%0d: got %h want %h", acc, got, exp_b);
          end
        end
        acc++;
      end
    end
    stall_prev = !rst && u_if.tvalid && !u_if.tready;
    prev = got;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_rdy) u_if.tready = 1'($urandom % 2);
  endtask

  task automatic wait_acc(int target, int budget);
    int n = 0;
    while (acc < target && n < budget) begin
      cyc();
      n++;
    end
    check("wait_acc", 32'(acc >= target), 32'd1);
  endtask

  task automatic check_reset();
    check("rst_tvalid", 32'(u_if.tvalid), 32'd0);
    check("rst_tuser", 32'(u_if.tuser), 32'b1000);
    check("rst_tdata", 32'(u_if.tdata), 32'd0);
    check("rst_fcnt", 32'(fc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  logic [23:0] c3;
  int          base;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    pat = 2'd0;
    col = 24'h123456;
    u_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset();

    // Frame 0: solid, full throughput.
    @(posedge clk);
    #1;
    push_frame(0, 24'h123456);
    en = 1'b1;
    @(negedge clk);
    check("lat_pre_tvalid", 32'(u_if.tvalid), 32'd0);
    @(negedge clk);
    check("lat_tvalid", 32'(u_if.tvalid), 32'd1);
    check("lat_tuser", 32'(u_if.tuser), 32'b0001);
    check("lat_tdata", 32'(u_if.tdata), 32'h123456);

    // Mid-frame switch to bars: applies from the next sof.
    wait_acc(100, 400);
    pat = 2'd1;
    push_frame(1, 24'h123456);
    check("busy_run", 32'(busy), 32'd1);
    wait_acc(FB, 400);
    check("fcnt_1", 32'(fc), 32'd1);

    // Ramp frame under random backpressure.
    wait_acc(FB + 100, 400);
    pat = 2'd2;
    push_frame(2, 24'h123456);
    rnd_rdy = 1;
    wait_acc(2 * FB, 1200);
    check("fcnt_2", 32'(fc), 32'd2);

    // Checker frame with a random foreground.
    wait_acc(2 * FB + 100, 1200);
    c3 = 24'($urandom);
    pat = 2'd3;
    col = c3;
    push_frame(3, c3);
    wait_acc(3 * FB, 1200);
    check("fcnt_3", 32'(fc), 32'd3);

    // Drop enable and change selection mid-frame: frame still completes.
    wait_acc(3 * FB + 50, 1200);
    en = 1'b0;
    pat = 2'd0;
    col = 24'($urandom);
    wait_acc(4 * FB, 1200);
    check("stop_tvalid", 32'(u_if.tvalid), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_fcnt", 32'(fc), 32'd4);
    repeat (5) cyc();
    check("idle_tvalid", 32'(u_if.tvalid), 32'd0);
    check("idle_beats", 32'(acc), 32'(4 * FB));
    check("q_empty_1", 32'(expq.size()), 32'd0);

    // Reset mid-frame.
    rnd_rdy = 0;
    u_if.tready = 1'b1;
    pat = 2'd2;
    en = 1'b1;
    push_frame(2, col);
    wait_acc(4 * FB + 100, 400);
    rst = 1'b1;
    en = 1'b0;
    u_if.tready = 1'b0;
    @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    expq.delete();

    // Restart after reset: frame begins again at (0,0).
    u_if.tready = 1'b1;
    pat = 2'd1;
    en = 1'b1;
    base = acc;
    push_frame(1, col);
    wait_acc(base + 10, 400);
    en = 1'b0;
    wait_acc(base + FB, 400);
    check("restart_fcnt", 32'(fc), 32'd1);
    check("q_empty_2", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
